// File: rtl/n8_l1_mult.sv
// Pipelined 8x8 unsigned approximate recursive multiplier, level-1 variant.
// Only the least-significant 2x2 block (a[1:0]*b[1:0]) is approximate: 3*3 yields 7.
module n8_l1_mult (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        out_valid,
  output logic [15:0] Y
);

  function automatic logic [3:0] mul2(input logic [1:0] x, input logic [1:0] y);
    return {2'b00, x} * {2'b00, y};
  endfunction

  // 3-bit result: every exact product except 3*3 fits; 3*3 saturates to 3'b111.
  function automatic logic [2:0] mul2_approx(input logic [1:0] x, input logic [1:0] y);
    if (x == 2'd3 && y == 2'd3) begin
      return 3'b111;
    end
    return {1'b0, x} * {1'b0, y};
  endfunction

  function automatic logic [7:0] mul4(input logic [3:0] x, input logic [3:0] y,
                                      input logic approx);
    logic [7:0] p_hh;
    logic [7:0] p_hl;
    logic [7:0] p_lh;
    logic [7:0] p_ll;
    p_hh = {4'b0000, mul2(x[3:2], y[3:2])};
    p_hl = {4'b0000, mul2(x[3:2], y[1:0])};
    p_lh = {4'b0000, mul2(x[1:0], y[3:2])};
    p_ll = approx ? {5'b00000, mul2_approx(x[1:0], y[1:0])}
                  : {4'b0000, mul2(x[1:0], y[1:0])};
    return (p_hh << 4) + ((p_hl + p_lh) << 2) + p_ll;
  endfunction

  logic [7:0]  phh_d, phl_d, plh_d, pll_d;
  logic [7:0]  phh_q, phl_q, plh_q, pll_q;
  logic        v1_q;
  logic [15:0] y_d, y_q;
  logic        ov_q;

  always_comb begin
    phh_d = mul4(a[7:4], b[7:4], 1'b0);
    phl_d = mul4(a[7:4], b[3:0], 1'b0);
    plh_d = mul4(a[3:0], b[7:4], 1'b0);
    pll_d = mul4(a[3:0], b[3:0], 1'b1);
  end

  always_comb begin
    logic [15:0] hh16;
    logic [15:0] mid16;
    logic [15:0] ll16;
    hh16  = {8'h00, phh_q};
    mid16 = {8'h00, phl_q} + {8'h00, plh_q};
    ll16  = {8'h00, pll_q};
    y_d   = (hh16 << 8) + (mid16 << 4) + ll16;
  end

  // Data registers load only on valid so Y holds its last result during bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phh_q <= '0;
      phl_q <= '0;
      plh_q <= '0;
      pll_q <= '0;
      v1_q  <= 1'b0;
      y_q   <= '0;
      ov_q  <= 1'b0;
    end else begin
      v1_q <= in_valid;
      ov_q <= v1_q;
      if (in_valid) begin
        phh_q <= phh_d;
        phl_q <= phl_d;
        plh_q <= plh_d;
        pll_q <= pll_d;
      end
      if (v1_q) begin
        y_q <= y_d;
      end
    end
  end

  assign Y         = y_q;
  assign out_valid = ov_q;

endmodule

// File: tb/tb_n8_l1_mult.sv
// Self-checking bench for n8_l1_mult: directed table, streaming, exhaustive, random and reset cases.
module tb_n8_l1_mult;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic [15:0] Y;

  n8_l1_mult dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .Y         (Y)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] y;
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  int          approx_cnt = 0;
  logic        prev_v = 1'b0;
  logic [15:0] prev_exp = '0;
  logic [15:0] prev_exact = '0;
  vec_t        vecs[6];

  function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y);
    int p;
    p = int'(x) * int'(y);
    if ((x % 4) == 3 && (y % 4) == 3) p = p - 2;
    return 16'(p);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one operand slot, take one edge, then check the result issued one slot earlier.
  task automatic cycle(input logic v, input logic [7:0] x, input logic [7:0] y,
                       input logic [15:0] e);
    in_valid = v;
    a        = x;
    b        = y;
    @(posedge clk);
    #1;
    check("out_valid", {31'b0, out_valid}, {31'b0, prev_v});
    if (prev_v) begin
      check("Y", {16'b0, Y}, {16'b0, prev_exp});
      if (Y != prev_exact) approx_cnt++;
    end
    prev_v     = v;
    prev_exp   = e;
    prev_exact = {8'h00, x} * {8'h00, y};
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rv;

    vecs[0] = '{a: 8'd12,  b: 8'd10,  y: 16'd120};
    vecs[1] = '{a: 8'd0,   b: 8'd255, y: 16'd0};
    vecs[2] = '{a: 8'd128, b: 8'd2,   y: 16'd256};
    vecs[3] = '{a: 8'd3,   b: 8'd3,   y: 16'd7};
    vecs[4] = '{a: 8'd255, b: 8'd255, y: 16'd65023};
    vecs[5] = '{a: 8'd7,   b: 8'd11,  y: 16'd75};

    // Reset held with live valid inputs.
    rst_n    = 1'b0;
    in_valid = 1'b1;
    a        = 8'($urandom);
    b        = 8'($urandom);
    repeat (4) begin
      @(posedge clk);
      #1;
      a = 8'($urandom);
      b = 8'($urandom);
      check("reset_Y", {16'b0, Y}, 32'd0);
      check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    prev_v   = 1'b0;

    // Directed table, each followed by a bubble so the result lands in isolation.
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, vecs[i].a, vecs[i].b, vecs[i].y);
      cycle(1'b0, 8'd0, 8'd0, 16'd0);
    end
    cycle(1'b0, 8'd0, 8'd0, 16'd0);

    // Back-to-back streaming.
    for (int i = 0; i < 256; i++) begin
      cycle(1'b1, 8'(i), 8'(255 - i), model(8'(i), 8'(255 - i)));
    end
    cycle(1'b0, 8'd0, 8'd0, 16'd0);

    // Exhaustive sweep, counting outputs that differ from the exact product.
    approx_cnt = 0;
    for (int i = 0; i < 65536; i++) begin
      cycle(1'b1, i[15:8], i[7:0], model(i[15:8], i[7:0]));
    end
    cycle(1'b0, 8'd0, 8'd0, 16'd0);
    check("approx_count", approx_cnt, 32'd4096);

    // Random stimulus with bubbles.
    for (int i = 0; i < 2000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rv = ($urandom_range(3, 0) != 0);
      cycle(rv, ra, rb, model(ra, rb));
    end
    cycle(1'b0, 8'd0, 8'd0, 16'd0);
    cycle(1'b0, 8'd0, 8'd0, 16'd0);

    // Mid-stream asynchronous reset with operands in flight.
    cycle(1'b1, 8'd200, 8'd150, model(8'd200, 8'd150));
    cycle(1'b1, 8'd99, 8'd77, model(8'd99, 8'd77));
    in_valid = 1'b1;
    a        = 8'd55;
    b        = 8'd44;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_Y", {16'b0, Y}, 32'd0);
    check("async_reset_out_valid", {31'b0, out_valid}, 32'd0);
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n  = 1'b1;
    prev_v = 1'b0;
    repeat (4) cycle(1'b0, 8'd0, 8'd0, 16'd0);

    // Recovery after reset.
    cycle(1'b1, 8'd15, 8'd15, model(8'd15, 8'd15));
    cycle(1'b0, 8'd0, 8'd0, 16'd0);
    cycle(1'b0, 8'd0, 8'd0, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
